// File: rtl/alu_operand_collector.sv
// ============================================================================
//  Module   : alu_operand_collector
//  Brief    : Operand collector in front of exec_alu. It takes one instruction
//             at a time and fetches its operands through a single-port register
//             file read. It then drives the ALU and hands the result to
//             writeback over a valid/ready handshake.
//  Options  : OPC_SAME_SRC_EN - reuse the rs_a read when rs_b == rs_a
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_collector #(
  parameter int RIDX_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [RIDX_W-1:0] issue_rs_a,
  input  logic [RIDX_W-1:0] issue_rs_b,
  input  logic [RIDX_W-1:0] issue_rd,
  input  logic              issue_imm_en,
  input  logic [31:0]       issue_imm,
  output logic              rf_rd_en,
  output logic [RIDX_W-1:0] rf_rd_addr,
  input  logic [31:0]       rf_rd_data,
  output logic [3:0]        alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RIDX_W-1:0] wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_is_fp16,
  output logic              busy,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_COL_B = 3'd3,
    S_EXEC  = 3'd4,
    S_WB    = 3'd5
  } state_t;

`ifdef OPC_SAME_SRC_EN
  localparam logic SAME_SRC_EN = 1'b1;
`else
  localparam logic SAME_SRC_EN = 1'b0;
`endif

  state_t              state;
  logic [3:0]          op_q;
  logic [RIDX_W-1:0]   rs_a_q;
  logic [RIDX_W-1:0]   rs_b_q;
  logic [RIDX_W-1:0]   rd_q;
  logic                imm_en_q;
  logic [31:0]         imm_q;
  logic [31:0]         opnd_a;
  logic                same_src;

  // A register-sourced B operand that names the same register as A can share A's read
  assign same_src    = SAME_SRC_EN && !imm_en_q && (rs_b_q == rs_a_q);
  assign issue_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= 4'h0;
      rs_a_q      <= '0;
      rs_b_q      <= '0;
      rd_q        <= '0;
      imm_en_q    <= 1'b0;
      imm_q       <= 32'h0;
      opnd_a      <= 32'h0;
      rf_rd_en    <= 1'b0;
      rf_rd_addr  <= '0;
      alu_op      <= 4'h0;
      alu_a       <= 32'h0;
      alu_b       <= 32'h0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= 32'h0;
      wb_is_fp16  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            op_q       <= issue_op;
            rs_a_q     <= issue_rs_a;
            rs_b_q     <= issue_rs_b;
            rd_q       <= issue_rd;
            imm_en_q   <= issue_imm_en;
            imm_q      <= issue_imm;
            rf_rd_en   <= 1'b1;
            rf_rd_addr <= issue_rs_a;
            state      <= S_RD_A;
          end
        end
        S_RD_A: begin
          if (!imm_en_q && !same_src) begin
            rf_rd_en   <= 1'b1;
            rf_rd_addr <= rs_b_q;
          end else begin
            rf_rd_en   <= 1'b0;
          end
          state <= S_RD_B;
        end
        S_RD_B: begin
          rf_rd_en <= 1'b0;
          opnd_a   <= rf_rd_data;
          // ALU inputs are loaded on entry to EXEC so they only move once per instruction
          if (imm_en_q || same_src) begin
            alu_op <= op_q;
            alu_a  <= rf_rd_data;
            alu_b  <= imm_en_q ? imm_q : rf_rd_data;
            state  <= S_EXEC;
          end else begin
            state  <= S_COL_B;
          end
        end
        S_COL_B: begin
          alu_op <= op_q;
          alu_a  <= opnd_a;
          alu_b  <= rf_rd_data;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          wb_data    <= alu_result;
          wb_rd      <= rd_q;
          wb_is_fp16 <= (op_q == 4'h8) || (op_q == 4'h9);
          wb_valid   <= 1'b1;
          state      <= S_WB;
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            retired_cnt <= retired_cnt + CNT_W'(1);
            state       <= S_IDLE;
          end
        end
        default: begin
          rf_rd_en <= 1'b0;
          wb_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
// ============================================================================
//  Module   : tb_alu_operand_collector
//  Brief    : Self-checking bench with directed vectors, multi-cycle corner
//             sequences and randomized instructions against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_collector;

  localparam int RIDX_W = 5;
  localparam int CNT_W  = 16;
`ifdef OPC_SAME_SRC_EN
  localparam logic SAME = 1'b1;
`else
  localparam logic SAME = 1'b0;
`endif
  localparam int SAME_LAT = SAME ? 4 : 5;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_op;
  logic [RIDX_W-1:0] issue_rs_a;
  logic [RIDX_W-1:0] issue_rs_b;
  logic [RIDX_W-1:0] issue_rd;
  logic              issue_imm_en;
  logic [31:0]       issue_imm;
  logic              rf_rd_en;
  logic [RIDX_W-1:0] rf_rd_addr;
  logic [31:0]       rf_rd_data;
  logic [3:0]        alu_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [31:0]       alu_result;
  logic              wb_valid;
  logic              wb_ready;
  logic [RIDX_W-1:0] wb_rd;
  logic [31:0]       wb_data;
  logic              wb_is_fp16;
  logic              busy;
  logic [CNT_W-1:0]  retired_cnt;

  alu_operand_collector #(.RIDX_W(RIDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rs_a(issue_rs_a), .issue_rs_b(issue_rs_b), .issue_rd(issue_rd),
    .issue_imm_en(issue_imm_en), .issue_imm(issue_imm),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_is_fp16(wb_is_fp16), .busy(busy), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: data valid only the cycle after a read strobe, garbage otherwise
  logic [31:0] rf [32];
  always @(posedge clk) rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : 32'hDEAD_BEEF;

  // Stand-in for exec_alu (op 8 doubles equal FP16 operands: 1.0+1.0=2.0)
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[4:0];
      4'h6: return a >> b[4:0];
      4'h8: return (a[15:0] == b[15:0]) ? {16'h0, a[15:0] + 16'h0400} : {16'h0, a[15:0] ^ b[15:0]};
      4'h9: return a - (b << 1);
      default: return 32'h0;
    endcase
  endfunction
  always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs_a, rs_b, rd;
    logic        imm_en;
    logic [31:0] imm;
    logic [31:0] exp_data;
    logic        exp_fp16;
    int          exp_lat;
    int          bp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic ie, input logic [31:0] imm,
                              input logic [31:0] ed, input logic fp, input int lat, input int bp);
    vec_t v;
    v.op = op; v.rs_a = a; v.rs_b = b; v.rd = d; v.imm_en = ie; v.imm = imm;
    v.exp_data = ed; v.exp_fp16 = fp; v.exp_lat = lat; v.bp = bp;
    return v;
  endfunction

  int          tests = 0;
  int          fails = 0;
  int unsigned exp_ret = 0;
  logic [3:0]  last_op = 4'h0;
  logic [31:0] last_a  = 32'h0;
  logic [31:0] last_b  = 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_op = v.op; issue_rs_a = v.rs_a; issue_rs_b = v.rs_b; issue_rd = v.rd;
    issue_imm_en = v.imm_en; issue_imm = v.imm;
  endtask

  task automatic run_instr(input vec_t v);
    int t, cyc, reads;
    logic ready_ok;
    logic [31:0] a_exp, b_exp;
    @(negedge clk);
    drive(v);
    issue_valid = 1'b1;
    wb_ready    = 1'b0;
    t = 0;
    while (!issue_ready && t < 20) begin @(negedge clk); t++; end
    chk("accept", {31'h0, issue_ready}, 32'h1);
    @(negedge clk);
    issue_valid = 1'b0;
    cyc = 1; reads = 0; ready_ok = 1'b1;
    chk("alu_a_hold", alu_a, last_a);
    chk("alu_b_hold", alu_b, last_b);
    chk("alu_op_hold", {28'h0, alu_op}, {28'h0, last_op});
    while (!wb_valid && cyc < 12) begin
      if (issue_ready) ready_ok = 1'b0;
      if (rf_rd_en) begin
        reads++;
        chk("rd_addr", {27'h0, rf_rd_addr}, {27'h0, (reads == 1) ? v.rs_a : v.rs_b});
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, v.exp_lat);
    chk("rf_reads", reads, (v.exp_lat == 4) ? 1 : 2);
    chk("ready_low_busy", {31'h0, ready_ok}, 32'h1);
    a_exp = rf[v.rs_a];
    b_exp = v.imm_en ? v.imm : rf[v.rs_b];
    chk("alu_a", alu_a, a_exp);
    chk("alu_b", alu_b, b_exp);
    last_a = a_exp; last_b = b_exp; last_op = v.op;
    chk("wb_data", wb_data, v.exp_data);
    chk("wb_rd", {27'h0, wb_rd}, {27'h0, v.rd});
    chk("wb_is_fp16", {31'h0, wb_is_fp16}, {31'h0, v.exp_fp16});
    for (int i = 0; i < v.bp; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, wb_valid}, 32'h1);
      chk("bp_data", wb_data, v.exp_data);
      chk("bp_rd", {27'h0, wb_rd}, {27'h0, v.rd});
      chk("bp_ready", {31'h0, issue_ready}, 32'h0);
      chk("bp_cnt", {16'h0, retired_cnt}, exp_ret & 32'hFFFF);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    exp_ret++;
    chk("retired_cnt", {16'h0, retired_cnt}, exp_ret & 32'hFFFF);
    chk("wb_valid_drop", {31'h0, wb_valid}, 32'h0);
    chk("ready_after_wb", {31'h0, issue_ready}, 32'h1);
  endtask

  vec_t        tbl [7];
  vec_t        b2b [3];
  logic [31:0] b2b_exp [3];
  logic [31:0] got_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    int accepts, idx;
    logic pend, quiet;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'h3C00; rf[6] = 32'hF0;

    tbl[0] = mk(4'h0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0,     32'd12,        1'b0, 5, 0);
    tbl[1] = mk(4'h8, 5'd4, 5'd0, 5'd9, 1'b1, 32'h3C00,  32'h0000_4000, 1'b1, 4, 0);
    tbl[2] = mk(4'h1, 5'd1, 5'd2, 5'd5, 1'b0, 32'h0,     32'hFFFF_FFFE, 1'b0, 5, 6);
    tbl[3] = mk(4'h4, 5'd6, 5'd6, 5'd8, 1'b0, 32'h0,     32'h0,         1'b0, SAME_LAT, 0);
    tbl[4] = mk(4'h7, 5'd1, 5'd2, 5'd7, 1'b0, 32'h0,     32'h0,         1'b0, 5, 1);
    tbl[5] = mk(4'h9, 5'd4, 5'd0, 5'd1, 1'b1, 32'h100,   32'h3A00,      1'b1, 4, 2);
    tbl[6] = mk(4'hF, 5'd6, 5'd0, 5'd2, 1'b1, 32'h1234,  32'h0,         1'b0, 4, 0);

    b2b[0] = mk(4'h0, 5'd1, 5'd2, 5'd10, 1'b0, 32'h0,  32'd12, 1'b0, 5, 0);
    b2b[1] = mk(4'h4, 5'd1, 5'd2, 5'd11, 1'b0, 32'h0,  32'd2,  1'b0, 5, 0);
    b2b[2] = mk(4'h2, 5'd6, 5'd0, 5'd12, 1'b1, 32'hFF, 32'hF0, 1'b0, 4, 0);
    b2b_exp[0] = 32'd12; b2b_exp[1] = 32'd2; b2b_exp[2] = 32'hF0;

    rst = 1'b1; issue_valid = 1'b0; wb_ready = 1'b0;
    drive(tbl[0]);
    repeat (3) @(negedge clk);
    chk("rst_issue_ready", {31'h0, issue_ready}, 32'h1);
    chk("rst_rf_rd_en", {31'h0, rf_rd_en}, 32'h0);
    chk("rst_rf_rd_addr", {27'h0, rf_rd_addr}, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_is_fp16", {31'h0, wb_is_fp16}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_retired", {16'h0, retired_cnt}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_instr(tbl[i]);

    // Back-to-back: issue_valid held across three instructions
    @(negedge clk);
    drive(b2b[0]);
    issue_valid = 1'b1; wb_ready = 1'b1;
    accepts = 0; idx = 0; pend = 1'b0;
    got_q.delete();
    for (int c = 0; c < 60; c++) begin
      if (wb_valid) got_q.push_back(wb_data);
      if (issue_valid && issue_ready) begin accepts++; pend = 1'b1; end
      @(negedge clk);
      if (pend) begin
        pend = 1'b0; idx++;
        if (idx < 3) drive(b2b[idx]); else issue_valid = 1'b0;
      end
      if (got_q.size() == 3) break;
    end
    wb_ready = 1'b0; issue_valid = 1'b0;
    chk("b2b_count", got_q.size(), 3);
    chk("b2b_accepts", accepts, 3);
    for (int i = 0; i < 3; i++)
      chk("b2b_data", (got_q.size() > i) ? got_q[i] : 32'hBAD0_BAD0, b2b_exp[i]);
    exp_ret += 3;
    chk("b2b_retired", {16'h0, retired_cnt}, exp_ret & 32'hFFFF);
    last_op = 4'h2; last_a = rf[6]; last_b = 32'hFF;

    // Reset while collecting B drops the instruction
    @(negedge clk);
    drive(tbl[0]); issue_valid = 1'b1;
    @(negedge clk); issue_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("colb_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0; last_op = 4'h0; last_a = 32'h0; last_b = 32'h0;
    chk("mid_rst_ready", {31'h0, issue_ready}, 32'h1);
    chk("mid_rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("mid_rst_retired", {16'h0, retired_cnt}, 32'h0);
    chk("mid_rst_rf_rd_en", {31'h0, rf_rd_en}, 32'h0);
    quiet = 1'b1;
    repeat (6) begin @(negedge clk); if (wb_valid || busy) quiet = 1'b0; end
    chk("mid_rst_quiet", {31'h0, quiet}, 32'h1);
    run_instr(tbl[0]);

    // Randomized instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      r.op     = 4'($urandom_range(0, 15));
      r.rs_a   = 5'($urandom_range(0, 31));
      r.rs_b   = ($urandom_range(0, 3) == 0) ? r.rs_a : 5'($urandom_range(0, 31));
      r.rd     = 5'($urandom_range(0, 31));
      r.imm_en = 1'($urandom_range(0, 1));
      r.imm    = $urandom;
      r.bp     = $urandom_range(0, 3);
      r.exp_data = alu_ref(r.op, rf[r.rs_a], r.imm_en ? r.imm : rf[r.rs_b]);
      r.exp_fp16 = (r.op == 4'h8) || (r.op == 4'h9);
      r.exp_lat  = r.imm_en ? 4 : ((SAME && r.rs_a == r.rs_b) ? 4 : 5);
      run_instr(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
